aira_ml_output_collector: RTL and testbench
===========================================

# aira_ml_output_collector

Consumer for the multi-port output stream of the `aira_ml` inference core. It accepts address-tagged result words from `N_PORTS` parallel output ports and assembles them into a `DEPTH`-word result frame. It asserts stall back to the core while the frame is drained, then serialises the frame word-by-word over a valid/ready stream toward the host link.

## Interface
- `N_OUTPUT`, 16, width of one result word.
- `N_PORTS`, 2, number of parallel output ports from the core.
- `N_ADDR`, 4, width of each port's word address.
- `DEPTH`, 16, words per result frame (≤ 2^`N_ADDR`).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_data`  in  `N_OUTPUT` × [`N_PORTS`]  result word per port (core `o_data`).
- `i_d_addr`  in  `N_ADDR` × [`N_PORTS`]  absolute frame word index per port (core `o_d_addr`).
- `i_d_valid`  in  1  all ports carry valid words this cycle (core `o_d_valid`).
- `o_stall`  out  1  core must hold outputs; drives core `i_stall`.
- `o_tx_data`  out  `N_OUTPUT`  serialised result word.
- `o_tx_valid`  out  1  `o_tx_data` valid.
- `o_tx_last`  out  1  current word is frame word `DEPTH-1`.
- `i_tx_ready`  in  1  downstream accepts word.
- `o_frame_count`  out  8  completed frames sent, wraps 255→0.
- `o_addr_err`  out  1  sticky: an address ≥ `DEPTH` was received.

## Operation
- Two states:
  - COLLECT: `o_stall`=0, `o_tx_valid`=0.
  - DRAIN: `o_stall`=1, `o_tx_valid`=1.
- COLLECT accept rule: on a clock edge with `i_d_valid`=1, each port p with `i_d_addr[p]` < `DEPTH` writes `i_data[p]` to `buf[i_d_addr[p]]` and sets `mask[i_d_addr[p]]`.
- Ports with an address ≥ `DEPTH` are dropped and set `o_addr_err`.
- Same address on several ports in one cycle: the highest port index wins.
- Re-written address: data overwritten, mask unchanged.
- COLLECT→DRAIN on the edge where the next-state mask is all ones, including the edge carrying the final write.
- DRAIN: `o_tx_data` = `buf[rd_ptr]`; `o_tx_last` = (`rd_ptr` == `DEPTH-1`).
  - On `o_tx_valid`&&`i_tx_ready`, `rd_ptr` increments.
  - On the transfer with `o_tx_last`=1: `rd_ptr`←0, `mask`←0, `o_frame_count`++, state←COLLECT.
- `i_d_valid` is ignored in DRAIN; the core honours `o_stall`.
- `o_tx_data` is held stable while `o_tx_valid`=1 and `i_tx_ready`=0.
- `o_addr_err` clears only on reset.
- Reset, asynchronous on `rst`=0:
  - state=COLLECT, mask=0, `rd_ptr`=0.
  - `o_stall`=0, `o_tx_valid`=0, `o_tx_last`=0, `o_tx_data`=0, `o_frame_count`=0, `o_addr_err`=0.
  - Buffer contents are not reset.
  - Reset mid-DRAIN discards the partial frame; no further tx words are produced.

## Timing
- `o_stall`, `o_tx_valid` and `o_tx_last` are decoded from registered state and `rd_ptr` only. There is no combinational path from inputs to outputs.
- Latency: final completing write on edge k → `o_tx_valid`=1, `o_stall`=1 and word 0 present during cycle k+1.
- Drain takes `DEPTH` cycles minimum at `i_tx_ready`=1 continuously.
- Last handshake on edge m → `o_stall`=0 in cycle m+1. The first write of the next frame can be accepted on edge m+1.
- Core throughput in COLLECT: one multi-port beat per cycle, no bubbles.

## Structure
- Package `aira_ml_io_pkg`:
  - `collector_state_t` enum {COLLECT, DRAIN}.
  - Default parameter constants shared with the input-side feeder.
- One sub-module, `aira_ml_result_buffer`:
  - `DEPTH`×`N_OUTPUT` register array, `N_PORTS` write ports with priority resolution.
  - Valid mask with `full` output and synchronous clear.
  - One combinational read port.
- The top holds the FSM, `rd_ptr`, frame counter and error flag.

## Test plan
- Ordered fill (defaults): 8 beats, port0 addr 2b / port1 addr 2b+1, data = 0x100+addr → 16 tx words 0x100..0x10F. `o_tx_last` only on 0x10F; `o_stall`=1 from the cycle after the 8th beat; `o_frame_count`=1.
- Out-of-order and overwrite: fill addrs in reverse order, and rewrite addr 5 with 0xBEEF before completion → word 5 reads 0xBEEF; DRAIN entered only when all 16 are set.
- Collision plus bad address: both ports addr 3 with 0xAAAA/0x5555 → 0x5555 stored. Port1 addr 15 with `DEPTH`=12 → dropped and `o_addr_err`=1 thereafter.
- Backpressure: `i_tx_ready` toggling 1,0,0,1 with a random 30% duty → words emitted in order with no loss or duplication; `o_tx_data` stable during stalls; `o_stall` held until the last handshake.
- Back-to-back frames: second frame beats presented while draining are ignored. The first beat after `o_stall` falls is accepted. 256 frames → `o_frame_count` wraps to 0.
- Reset mid-DRAIN after 5 words: all outputs return to reset values asynchronously. After release a fresh frame of 16 words transmits correctly.

Source files
------------

// File: rtl/aira_ml_io_pkg.sv
// Shared types and default parameters for the aira_ml host-side I/O blocks.
package aira_ml_io_pkg;

  localparam int unsigned AIRA_N_OUTPUT    = 16;
  localparam int unsigned AIRA_N_PORTS     = 2;
  localparam int unsigned AIRA_N_ADDR      = 4;
  localparam int unsigned AIRA_DEPTH       = 16;
  localparam int unsigned AIRA_FRAME_CNT_W = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collector_state_t;

endpackage

// File: rtl/aira_ml_result_buffer.sv
// Frame buffer for the output collector: multi-port writes where the highest
// port index wins a collision, a per-word valid mask with synchronous clear,
// and one combinational read port.
module aira_ml_result_buffer
  import aira_ml_io_pkg::*;
#(
  parameter int unsigned N_OUTPUT = AIRA_N_OUTPUT,
  parameter int unsigned N_PORTS  = AIRA_N_PORTS,
  parameter int unsigned N_ADDR   = AIRA_N_ADDR,
  parameter int unsigned DEPTH    = AIRA_DEPTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               we_i,
  input  logic [N_PORTS-1:0][N_OUTPUT-1:0]   wdata_i,
  input  logic [N_PORTS-1:0][N_ADDR-1:0]     waddr_i,
  input  logic                               clr_i,
  input  logic [N_ADDR-1:0]                  raddr_i,
  output logic [N_OUTPUT-1:0]                rdata_o,
  output logic                               full_d_o,
  output logic                               addr_err_o
);

  localparam logic [N_ADDR:0] DepthLim = (N_ADDR+1)'(DEPTH);

  logic [N_OUTPUT-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]    mask_q;
  logic [DEPTH-1:0]    mask_d;
  logic [N_PORTS-1:0]  in_range;
  logic [N_PORTS-1:0]  port_ok;

  // Qualify each port: only in-range addresses may touch the buffer.
  always_comb begin
    in_range = '0;
    port_ok  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      in_range[p] = ({1'b0, waddr_i[p]} < DepthLim);
      port_ok[p]  = we_i && in_range[p];
    end
    addr_err_o = we_i && !(&in_range);
  end

  // Next-state mask; full_d_o looks ahead so the FSM can switch on the completing write.
  always_comb begin
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (port_ok[p]) begin
          mask_d[waddr_i[p]] = 1'b1;
        end
      end
    end
  end

  assign full_d_o = &mask_d;

  // Valid mask register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Data array is not reset; later ports are assigned last so they win collisions.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (port_ok[p]) begin
        mem_q[waddr_i[p]] <= wdata_i[p];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aira_ml_output_collector.sv
// Collects address-tagged result words from the inference core into a frame,
// then stalls the core and streams the frame out over valid/ready.
module aira_ml_output_collector
  import aira_ml_io_pkg::*;
#(
  parameter int unsigned N_OUTPUT = AIRA_N_OUTPUT,
  parameter int unsigned N_PORTS  = AIRA_N_PORTS,
  parameter int unsigned N_ADDR   = AIRA_N_ADDR,
  parameter int unsigned DEPTH    = AIRA_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0][N_OUTPUT-1:0]  i_data,
  input  logic [N_PORTS-1:0][N_ADDR-1:0]    i_d_addr,
  input  logic                              i_d_valid,
  output logic                              o_stall,
  output logic [N_OUTPUT-1:0]               o_tx_data,
  output logic                              o_tx_valid,
  output logic                              o_tx_last,
  input  logic                              i_tx_ready,
  output logic [AIRA_FRAME_CNT_W-1:0]       o_frame_count,
  output logic                              o_addr_err
);

  localparam logic [N_ADDR-1:0] LastIdx = N_ADDR'(DEPTH - 1);

  collector_state_t              state_q, state_d;
  logic [N_ADDR-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AIRA_FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                          addr_err_q, addr_err_d;

  logic                          in_drain;
  logic                          at_last;
  logic                          tx_fire;
  logic                          buf_we;
  logic                          buf_clr;
  logic                          buf_full_d;
  logic                          buf_addr_err;
  logic [N_OUTPUT-1:0]           buf_rdata;

  assign in_drain = (state_q == DRAIN);
  assign at_last  = (rd_ptr_q == LastIdx);
  assign tx_fire  = in_drain && i_tx_ready;
  assign buf_we   = i_d_valid && !in_drain;
  assign buf_clr  = tx_fire && at_last;

  aira_ml_result_buffer #(
    .N_OUTPUT (N_OUTPUT),
    .N_PORTS  (N_PORTS),
    .N_ADDR   (N_ADDR),
    .DEPTH    (DEPTH)
  ) u_buffer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .we_i       (buf_we),
    .wdata_i    (i_data),
    .waddr_i    (i_d_addr),
    .clr_i      (buf_clr),
    .raddr_i    (rd_ptr_q),
    .rdata_o    (buf_rdata),
    .full_d_o   (buf_full_d),
    .addr_err_o (buf_addr_err)
  );

  // Next-state logic: enter DRAIN on the completing write, leave after the last handshake.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    addr_err_d  = addr_err_q | buf_addr_err;
    case (state_q)
      COLLECT: begin
        if (buf_full_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tx_fire) begin
          if (at_last) begin
            rd_ptr_d    = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = COLLECT;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State, read pointer, frame counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign o_stall       = in_drain;
  assign o_tx_valid    = in_drain;
  assign o_tx_last     = in_drain && at_last;
  assign o_tx_data     = in_drain ? buf_rdata : '0;
  assign o_frame_count = frame_cnt_q;
  assign o_addr_err    = addr_err_q;

endmodule

// File: tb/tb_aira_ml_output_collector.sv
// Directed bench for the output collector: a default instance plus a DEPTH=12
// instance used to exercise out-of-range addresses.
module tb_aira_ml_output_collector;

  logic              clk = 1'b0;
  logic              rst;

  logic [1:0][15:0]  i_data;
  logic [1:0][3:0]   i_d_addr;
  logic              i_d_valid;
  logic              i_tx_ready;
  logic              o_stall;
  logic [15:0]       o_tx_data;
  logic              o_tx_valid;
  logic              o_tx_last;
  logic [7:0]        o_frame_count;
  logic              o_addr_err;

  logic [1:0][15:0]  i_data12;
  logic [1:0][3:0]   i_d_addr12;
  logic              i_d_valid12;
  logic              i_tx_ready12;
  logic              o_stall12;
  logic [15:0]       o_tx_data12;
  logic              o_tx_valid12;
  logic              o_tx_last12;
  logic [7:0]        o_frame_count12;
  logic              o_addr_err12;

  int                checks = 0;
  int                errors = 0;
  logic [15:0]       expWords [16];
  logic [7:0]        expFrames;

  always #5 clk = ~clk;

  aira_ml_output_collector dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_d_addr      (i_d_addr),
    .i_d_valid     (i_d_valid),
    .o_stall       (o_stall),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .o_tx_last     (o_tx_last),
    .i_tx_ready    (i_tx_ready),
    .o_frame_count (o_frame_count),
    .o_addr_err    (o_addr_err)
  );

  aira_ml_output_collector #(.DEPTH(12)) dut12 (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data12),
    .i_d_addr      (i_d_addr12),
    .i_d_valid     (i_d_valid12),
    .o_stall       (o_stall12),
    .o_tx_data     (o_tx_data12),
    .o_tx_valid    (o_tx_valid12),
    .o_tx_last     (o_tx_last12),
    .i_tx_ready    (i_tx_ready12),
    .o_frame_count (o_frame_count12),
    .o_addr_err    (o_addr_err12)
  );

  task automatic beat(input logic [3:0] a0, input logic [15:0] d0,
                      input logic [3:0] a1, input logic [15:0] d1);
    i_d_valid   = 1'b1;
    i_d_addr[0] = a0;
    i_data[0]   = d0;
    i_d_addr[1] = a1;
    i_data[1]   = d1;
    @(posedge clk); #1;
    i_d_valid = 1'b0;
  endtask

  task automatic beat12(input logic [3:0] a0, input logic [15:0] d0,
                        input logic [3:0] a1, input logic [15:0] d1);
    i_d_valid12   = 1'b1;
    i_d_addr12[0] = a0;
    i_data12[0]   = d0;
    i_d_addr12[1] = a1;
    i_data12[1]   = d1;
    @(posedge clk); #1;
    i_d_valid12 = 1'b0;
  endtask

  task automatic fill_ordered(input logic [15:0] base);
    for (int b = 0; b < 8; b++) begin
      beat(4'(2*b), base + 16'(2*b), 4'(2*b+1), base + 16'(2*b+1));
    end
    for (int i = 0; i < 16; i++) expWords[i] = base + 16'(i);
  endtask

  task automatic drain_frame(input string name, input bit bp, input bit junk);
    int idx;
    int cyc;
    bit rdy;
    bit bad;
    idx = 0;
    cyc = 0;
    bad = 1'b0;
    while (idx < 16 && cyc < 400) begin
      if (!bp) rdy = 1'b1;
      else if (cyc < 4) rdy = (cyc == 0 || cyc == 3);
      else rdy = ($urandom_range(0, 99) < 30);
      i_tx_ready = rdy;
      if (junk) begin
        i_d_valid   = 1'b1;
        i_d_addr[0] = 4'd14;
        i_d_addr[1] = 4'd15;
        i_data[0]   = 16'hDEAD;
        i_data[1]   = 16'hDEAD;
      end
      checks++;
      if (o_tx_valid !== 1'b1 || o_stall !== 1'b1) begin
        errors++; bad = 1'b1;
        $display("[TB] FAIL %s_valid word %0d: got valid=%b stall=%b expected 1/1", name, idx, o_tx_valid, o_stall);
      end
      checks++;
      if (o_tx_data !== expWords[idx]) begin
        errors++; bad = 1'b1;
        $display("[TB] FAIL %s_data word %0d: got %h expected %h", name, idx, o_tx_data, expWords[idx]);
      end
      checks++;
      if (o_tx_last !== (idx == 15)) begin
        errors++; bad = 1'b1;
        $display("[TB] FAIL %s_last word %0d: got %b expected %b", name, idx, o_tx_last, (idx == 15));
      end
      if (bad) break;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    i_tx_ready = 1'b0;
    i_d_valid  = 1'b0;
    checks++;
    if (idx != 16) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d words expected 16", name, idx);
    end
    checks++;
    if (o_stall !== 1'b0 || o_tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_end: got stall=%b valid=%b expected 0/0", name, o_stall, o_tx_valid);
    end
    checks++;
    if (o_frame_count !== expFrames) begin
      errors++;
      $display("[TB] FAIL %s_frames: got %0d expected %0d", name, o_frame_count, expFrames);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({o_stall, o_tx_valid, o_tx_last, o_addr_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {o_stall, o_tx_valid, o_tx_last, o_addr_err});
    end
    checks++;
    if (o_tx_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0000", o_tx_data);
    end
    checks++;
    if (o_frame_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_frames: got %0d expected 0", o_frame_count);
    end
    checks++;
    if ({o_stall12, o_tx_valid12, o_addr_err12} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_dut12: got %b expected 000", {o_stall12, o_tx_valid12, o_addr_err12});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_stall: got %b expected 0", o_stall);
    end
    expFrames = 8'd0;
  endtask

  task automatic test_ordered();
    for (int b = 0; b < 8; b++) begin
      beat(4'(2*b), 16'h0100 + 16'(2*b), 4'(2*b+1), 16'h0100 + 16'(2*b+1));
      if (b == 6) begin
        checks++;
        if (o_stall !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ordered_early_stall: got %b expected 0", o_stall);
        end
      end
    end
    checks++;
    if (o_stall !== 1'b1 || o_tx_valid !== 1'b1 || o_tx_data !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL ordered_latency: got stall=%b valid=%b data=%h expected 1/1/0100", o_stall, o_tx_valid, o_tx_data);
    end
    for (int i = 0; i < 16; i++) expWords[i] = 16'h0100 + 16'(i);
    expFrames++;
    drain_frame("ordered", 1'b0, 1'b0);
  endtask

  task automatic test_out_of_order();
    for (int b = 7; b >= 3; b--) begin
      beat(4'(2*b+1), 16'h0200 + 16'(2*b+1), 4'(2*b), 16'h0200 + 16'(2*b));
    end
    beat(4'd5, 16'h0205, 4'd4, 16'h0204);
    beat(4'd4, 16'h0204, 4'd5, 16'hBEEF);
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ooo_rewrite_stall: got %b expected 0", o_stall);
    end
    beat(4'd3, 16'h0203, 4'd2, 16'h0202);
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ooo_14_stall: got %b expected 0", o_stall);
    end
    beat(4'd1, 16'h0201, 4'd0, 16'h0200);
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ooo_full_stall: got %b expected 1", o_stall);
    end
    for (int i = 0; i < 16; i++) expWords[i] = 16'h0200 + 16'(i);
    expWords[5] = 16'hBEEF;
    expFrames++;
    drain_frame("ooo", 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    beat(4'd3, 16'hAAAA, 4'd3, 16'h5555);
    beat(4'd0, 16'h0300, 4'd1, 16'h0301);
    beat(4'd2, 16'h0302, 4'd4, 16'h0304);
    for (int a = 5; a < 15; a += 2) begin
      beat(4'(a), 16'h0300 + 16'(a), 4'(a+1), 16'h0300 + 16'(a+1));
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision_early_stall: got %b expected 0", o_stall);
    end
    beat(4'd15, 16'h030F, 4'd15, 16'h030F);
    for (int i = 0; i < 16; i++) expWords[i] = 16'h0300 + 16'(i);
    expWords[3] = 16'h5555;
    expFrames++;
    drain_frame("collision", 1'b0, 1'b0);
  endtask

  task automatic test_addr_err();
    int idx;
    checks++;
    if (o_addr_err12 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addr_err_before: got %b expected 0", o_addr_err12);
    end
    beat12(4'd0, 16'h0900, 4'd15, 16'h09FF);
    checks++;
    if (o_addr_err12 !== 1'b1 || o_stall12 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addr_err_set: got err=%b stall=%b expected 1/0", o_addr_err12, o_stall12);
    end
    for (int a = 1; a < 11; a += 2) begin
      beat12(4'(a), 16'h0900 + 16'(a), 4'(a+1), 16'h0900 + 16'(a+1));
    end
    checks++;
    if (o_stall12 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL addr_err_early_stall: got %b expected 0", o_stall12);
    end
    beat12(4'd11, 16'h090B, 4'd11, 16'h090B);
    idx = 0;
    i_tx_ready12 = 1'b1;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      checks++;
      if (o_tx_valid12 !== 1'b1 || o_tx_data12 !== (16'h0900 + 16'(idx))) begin
        errors++;
        $display("[TB] FAIL d12_word %0d: got valid=%b data=%h expected 1/%h", idx, o_tx_valid12, o_tx_data12, 16'h0900 + 16'(idx));
        break;
      end
      checks++;
      if (o_tx_last12 !== (idx == 11)) begin
        errors++;
        $display("[TB] FAIL d12_last %0d: got %b expected %b", idx, o_tx_last12, (idx == 11));
      end
      @(posedge clk); #1;
      idx++;
    end
    i_tx_ready12 = 1'b0;
    checks++;
    if (idx != 12) begin
      errors++;
      $display("[TB] FAIL d12_count: got %0d expected 12", idx);
    end
    checks++;
    if (o_stall12 !== 1'b0 || o_frame_count12 !== 8'd1 || o_addr_err12 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL d12_end: got stall=%b frames=%0d err=%b expected 0/1/1", o_stall12, o_frame_count12, o_addr_err12);
    end
  endtask

  task automatic test_backpressure();
    fill_ordered(16'h0400);
    expFrames++;
    drain_frame("backpressure", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_ordered(16'h0500);
    expFrames++;
    drain_frame("b2b_first", 1'b0, 1'b1);
    for (int b = 0; b < 7; b++) begin
      beat(4'(2*b), 16'h0600 + 16'(2*b), 4'(2*b+1), 16'h0600 + 16'(2*b+1));
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_junk_accepted: got stall=%b expected 0", o_stall);
    end
    beat(4'd14, 16'h060E, 4'd15, 16'h060F);
    for (int i = 0; i < 16; i++) expWords[i] = 16'h0600 + 16'(i);
    expFrames++;
    drain_frame("b2b_second", 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    bit ok;
    while (expFrames != 8'd255) begin
      fill_ordered(16'h0A00);
      i_tx_ready = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (o_stall === 1'b0) begin
          ok = 1'b1;
          break;
        end
      end
      i_tx_ready = 1'b0;
      expFrames++;
      if (!ok) begin
        checks++;
        errors++;
        $display("[TB] FAIL wrap_timeout: got stall=%b expected 0", o_stall);
        break;
      end
    end
    checks++;
    if (o_frame_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL wrap_255: got %0d expected 255", o_frame_count);
    end
    fill_ordered(16'h0B00);
    expFrames++;
    drain_frame("wrap_to_0", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    fill_ordered(16'h0700);
    i_tx_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (o_tx_data !== 16'h0705) begin
      errors++;
      $display("[TB] FAIL mid_drain_word5: got %h expected 0705", o_tx_data);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({o_stall, o_tx_valid, o_tx_last, o_addr_err} !== 4'b0000 || o_tx_data !== 16'h0000 || o_frame_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got flags=%b data=%h frames=%0d expected 0000/0000/0", {o_stall, o_tx_valid, o_tx_last, o_addr_err}, o_tx_data, o_frame_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_tx_valid !== 1'b0 || o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got valid=%b stall=%b expected 0/0", o_tx_valid, o_stall);
    end
    i_tx_ready = 1'b0;
    expFrames = 8'd0;
    fill_ordered(16'h0800);
    expFrames++;
    drain_frame("post_reset", 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    i_data       = '0;
    i_d_addr     = '0;
    i_d_valid    = 1'b0;
    i_tx_ready   = 1'b0;
    i_data12     = '0;
    i_d_addr12   = '0;
    i_d_valid12  = 1'b0;
    i_tx_ready12 = 1'b0;
    expFrames    = 8'd0;

    test_reset();
    test_ordered();
    test_out_of_order();
    test_collision();
    test_addr_err();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
